// File: rtl/fmul_pkg.sv
// Shared constants and types for the single-precision multiply post stage.
// Holds IEEE-754 field limits, the canonical quiet NaN and flag bit indices.
package fmul_pkg;

    localparam int          FP_BIAS = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    // Bit positions inside the 3-bit {invalid, overflow, underflow} vector
    typedef enum logic [1:0] {
        FLG_UNF = 2'd0,
        FLG_OVF = 2'd1,
        FLG_INV = 2'd2
    } flag_idx_e;

    // Operand triple captured in the S1 register; c sign is never used
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [30:0] c;
    } s1_t;

endpackage

// File: rtl/fmul_post_stage_if.sv
// Handshake bundle for fmul_post_stage: input triple, output result, flags.
// master = producer/consumer side (bench), slave = the post stage itself.
interface fmul_post_stage_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      c;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic [2:0]       res_flags;
    logic [2:0]       sticky_flags;
    logic             flag_clr;
    logic [CNT_W-1:0] res_count;

    modport master (
        output in_valid, a, b, c, out_ready, flag_clr,
        input  in_ready, out_valid, result, res_flags,
        input  sticky_flags, res_count
    );

    modport slave (
        input  in_valid, a, b, c, out_ready, flag_clr,
        output in_ready, out_valid, result, res_flags,
        output sticky_flags, res_count
    );
endinterface

// File: rtl/fmul_classify.sv
// Combinational fix-up of a raw multiplier product: specials, exponent, flags.
// Ports: a, b operands; c raw product (no sign); result, flags {inv,ovf,unf}.
module fmul_classify
    import fmul_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [30:0] c,
    output logic [31:0] result,
    output logic [2:0]  flags
);

    logic [7:0]        ea, eb;
    logic              sign;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [9:0] ez, ez1, ef;
    logic              norm;

    always_comb begin
        ea     = a[30:23];
        eb     = b[30:23];
        sign   = a[31] ^ b[31];
        a_nan  = (ea == 8'(EXP_MAX)) && (a[22:0] != '0);
        b_nan  = (eb == 8'(EXP_MAX)) && (b[22:0] != '0);
        a_inf  = (ea == 8'(EXP_MAX)) && (a[22:0] == '0);
        b_inf  = (eb == 8'(EXP_MAX)) && (b[22:0] == '0);
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        ez     = 10'(ea) + 10'(eb) - 10'(FP_BIAS);
        ez1    = ez + 10'sd1;
        // The multiplier bumps the exponent when the mantissa product >= 2
        norm   = (c[30:23] == ez1[7:0]);
        ef     = ez + {9'd0, norm};
        result = '0;
        flags  = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result         = QNAN;
            flags[FLG_INV] = 1'b1;
        end else if (a_inf || b_inf) begin
            result = {sign, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            result = {sign, 31'h0};
        end else if (ef >= 10'sd255) begin
            result         = {sign, 8'hFF, 23'h0};
            flags[FLG_OVF] = 1'b1;
        end else if (ef <= 10'sd0) begin
            result         = {sign, 31'h0};
            flags[FLG_UNF] = 1'b1;
        end else begin
            result = {sign, ef[7:0], c[22:0]};
        end
    end

endmodule

// File: rtl/fmul_post_stage.sv
// Registered multiplier post stage: S1 capture, classify, DEPTH-entry buffer.
// Ports: clk, rst (sync high), io slave bundle (in/out handshake, flags, count).
module fmul_post_stage
    import fmul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    fmul_post_stage_if.slave  io
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 2;

    s1_t              s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [31:0]      res_mem_q [DEPTH];
    logic [31:0]      res_mem_d [DEPTH];
    logic [2:0]       flg_mem_q [DEPTH];
    logic [2:0]       flg_mem_d [DEPTH];
    logic [2:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [OCC_W-1:0] occ;
    logic             accept, wr, rd;
    logic [31:0]      cls_res;
    logic [2:0]       cls_flags;
    logic             unused_c_sign;

    assign unused_c_sign = io.c[31];

    fmul_classify u_classify (
        .a      (s1_q.a),
        .b      (s1_q.b),
        .c      (s1_q.c),
        .result (cls_res),
        .flags  (cls_flags)
    );

    // S1 always drains into the buffer next cycle, so counting it as
    // occupied guarantees a free slot without looking at out_ready.
    assign occ         = count_q + OCC_W'(s1_valid_q);
    assign io.in_ready = occ < OCC_W'(DEPTH);
    assign accept      = io.in_valid && io.in_ready;
    assign wr          = s1_valid_q;
    assign rd          = (count_q != '0) && io.out_ready;

    assign io.out_valid    = count_q != '0;
    assign io.result       = res_mem_q[rd_ptr_q];
    assign io.res_flags    = flg_mem_q[rd_ptr_q];
    assign io.sticky_flags = sticky_q;
    assign io.res_count    = cnt_q;

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = accept;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        res_mem_d  = res_mem_q;
        flg_mem_d  = flg_mem_q;
        cnt_d      = cnt_q;
        // Clear first so a bit set in the same cycle survives
        sticky_d   = io.flag_clr ? 3'b000 : sticky_q;
        count_d    = count_q + OCC_W'(wr) - OCC_W'(rd);
        if (accept) begin
            s1_d = '{a: io.a, b: io.b, c: io.c[30:0]};
        end
        if (wr) begin
            res_mem_d[wr_ptr_q] = cls_res;
            flg_mem_d[wr_ptr_q] = cls_flags;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            sticky_d            = sticky_d | cls_flags;
            cnt_d               = cnt_q + CNT_W'(1);
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            res_mem_q  <= '{default: '0};
            flg_mem_q  <= '{default: '0};
            sticky_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            res_mem_q  <= res_mem_d;
            flg_mem_q  <= flg_mem_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fmul_post_stage.sv
// Bench for fmul_post_stage: vector table through a scoreboard plus
// hand sequences for latency, sticky flags, backpressure and reset.
module tb_fmul_post_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmul_post_stage_if #(.CNT_W(16)) io ();

    fmul_post_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
    } exp_t;

    int   errs   = 0;
    int   checks = 0;
    int   n_wr   = 0;
    bit   mon_en = 0;
    exp_t sb[$];
    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    // Handshake commits at the following posedge; out_ready is stable here
    always @(negedge clk) begin
        if (mon_en && !rst && io.out_valid && io.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", io.result, e.res);
                chk("res_flags", 32'(io.res_flags), 32'(e.fl));
            end
        end
    end

    task automatic send(input vec_t v);
        bit done;
        done = 0;
        io.in_valid = 1'b1;
        io.a = v.a;
        io.b = v.b;
        io.c = v.c;
        for (int i = 0; i < 60 && !done; i++) begin
            bit r;
            @(negedge clk);
            r = io.in_ready;
            @(posedge clk);
            if (r) begin
                sb.push_back('{res: v.res, fl: v.fl});
                n_wr++;
                done = 1;
            end
        end
        #1;
        io.in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !io.out_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 32'h40C0_0000, 3'b000};
        tbl[1]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h1234_5678, 32'h7F80_0000, 3'b010};
        tbl[2]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 32'h0000_0000, 3'b001};
        tbl[3]  = '{32'h8000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h8000_0000, 3'b000};
        tbl[4]  = '{32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100};
        tbl[5]  = '{32'hFF80_0000, 32'h3F80_0000, 32'h0000_0000, 32'hFF80_0000, 3'b000};
        tbl[6]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 32'h4010_0000, 3'b000};
        tbl[7]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100};
        tbl[8]  = '{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 32'hC0C0_0000, 3'b000};
        tbl[9]  = '{32'h5F80_0000, 32'h5F80_0000, 32'h7F80_0000, 32'h7F80_0000, 3'b010};
        tbl[10] = '{32'h5F80_0000, 32'h5F00_0000, 32'h7F00_0000, 32'h7F00_0000, 3'b000};
        tbl[11] = '{32'h5F80_0000, 32'h5F00_0000, 32'h7F80_0000, 32'h7F80_0000, 3'b010};
        tbl[12] = '{32'h2000_0000, 32'h1F80_0000, 32'h0000_0000, 32'h0000_0000, 3'b001};
        tbl[13] = '{32'h2000_0000, 32'h2000_0000, 32'h0080_0000, 32'h0080_0000, 3'b000};

        rst = 1'b1;
        io.in_valid = 1'b0;
        io.a = '0;
        io.b = '0;
        io.c = '0;
        io.out_ready = 1'b1;
        io.flag_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(io.in_ready), 32'd1);
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_result", io.result, 32'd0);
        chk("rst_res_flags", 32'(io.res_flags), 32'd0);
        chk("rst_sticky", 32'(io.sticky_flags), 32'd0);
        chk("rst_count", 32'(io.res_count), 32'd0);
        rst = 1'b0;
        mon_en = 1;

        // Latency: accept edge, then one cycle in S1, then visible
        send(tbl[0]);
        chk("lat_n1_out_valid", 32'(io.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_n2_out_valid", 32'(io.out_valid), 32'd1);
        chk("lat_res_count", 32'(io.res_count), 32'd1);
        drain();

        send(tbl[1]);
        drain();
        chk("sticky_ovf", 32'(io.sticky_flags), 32'b010);
        io.flag_clr = 1'b1;
        @(posedge clk);
        #1;
        io.flag_clr = 1'b0;
        chk("sticky_clr", 32'(io.sticky_flags), 32'b000);

        // Clear requested in the same cycle the underflow result is written
        send(tbl[2]);
        io.flag_clr = 1'b1;
        @(posedge clk);
        #1;
        io.flag_clr = 1'b0;
        chk("sticky_set_wins", 32'(io.sticky_flags), 32'b001);
        drain();

        for (int i = 0; i < 14; i++) send(tbl[i]);
        drain();
        chk("table_count", 32'(io.res_count), 32'(n_wr[15:0]));
        chk("table_sticky", 32'(io.sticky_flags), 32'b111);

        // Backpressure: 4 offered back-to-back with the consumer stalled
        io.out_ready = 1'b0;
        begin
            int nacc;
            nacc = 0;
            for (int i = 0; i < 4; i++) begin
                bit r;
                io.in_valid = 1'b1;
                io.a = tbl[6 + nacc].a;
                io.b = tbl[6 + nacc].b;
                io.c = tbl[6 + nacc].c;
                @(negedge clk);
                r = io.in_ready;
                @(posedge clk);
                if (r) begin
                    sb.push_back('{res: tbl[6 + nacc].res, fl: tbl[6 + nacc].fl});
                    n_wr++;
                    nacc++;
                end
                #1;
            end
            io.in_valid = 1'b0;
            chk("bp_accepts", 32'(nacc), 32'd2);
            chk("bp_in_ready", 32'(io.in_ready), 32'd0);
            chk("bp_out_valid", 32'(io.out_valid), 32'd1);
            chk("bp_head_held", io.result, tbl[6].res);
            io.out_ready = 1'b1;
            send(tbl[8]);
            send(tbl[9]);
            drain();
            chk("bp_count", 32'(io.res_count), 32'(n_wr[15:0]));
        end

        // Reset with a full buffer discards everything
        io.out_ready = 1'b0;
        send(tbl[12]);
        send(tbl[13]);
        repeat (2) @(posedge clk);
        #1;
        chk("full_in_ready", 32'(io.in_ready), 32'd0);
        chk("full_out_valid", 32'(io.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
        chk("mid_rst_count", 32'(io.res_count), 32'd0);
        chk("mid_rst_sticky", 32'(io.sticky_flags), 32'd0);
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(io.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fmul_post_stage.md
Name: fmul_post_stage

Overview:
- Registered post-processing stage that sits directly downstream of the combinational single-precision multiplier.
- Captures the operands a, b and the raw product c, then re-derives the true exponent to detect overflow and underflow.
- Substitutes IEEE-754 special results (zero, inf, NaN) that the multiplier does not handle.
- Delivers results through a valid/ready output buffer and keeps sticky exception flags plus a result counter.

Parameters:
- DEPTH, 2, output buffer entries (power of two, >=2).
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b/c triple is valid.
- in_ready  output  1  stage can accept a triple this cycle.
- a  input  32  multiplier operand A (IEEE-754 single).
- b  input  32  multiplier operand B.
- c  input  32  raw multiplier product for a, b.
- out_valid  output  1  result at head of buffer is valid.
- out_ready  input  1  consumer takes the head this cycle.
- result  output  32  final IEEE-754 product.
- res_flags  output  3  per-result {invalid, overflow, underflow}.
- sticky_flags  output  3  accumulated {invalid, overflow, underflow}.
- flag_clr  input  1  clear sticky_flags.
- res_count  output  CNT_W  number of results written to the buffer, wraps.

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, res_flags=0, sticky_flags=0, res_count=0. S1 and the buffer are emptied. Reset mid-operation discards all in-flight data.
- Accept rule: a triple is accepted when in_valid&&in_ready. in_ready = (s1_valid + buf_count) < DEPTH, computed from registered state only, with no combinational path from out_ready.
- Latency:
  - Cycle N: accept into S1.
  - Cycle N+1: classify S1 and write the buffer.
  - Cycle N+2: out_valid=1 if the buffer was empty.
  - Full throughput of 1 result/cycle while out_ready=1.
- Classification, first match wins (ea=a[30:23], eb=b[30:23], fa/fb=fractions, sign=a[31]^b[31]):
  1. NaN operand (e=255, f!=0), or inf×zero → 0x7FC00000, invalid=1.
  2. Either operand inf → {sign,8'hFF,23'h0}.
  3. Either operand e=0 (zero or denormal, flushed) → {sign,31'h0}.
  4. Otherwise:
     - ez = ea+eb-127 as a 10-bit signed value.
     - norm = (c[30:23] == (ez+1)[7:0]).
     - ef = ez+norm.
     - ef>=255 → {sign,8'hFF,23'h0}, overflow=1.
     - ef<=0 → {sign,31'h0}, underflow=1.
     - else result={sign,ef[7:0],c[22:0]}.
- Buffer:
  - Circular, DEPTH entries, read/write pointers wrap modulo DEPTH.
  - Simultaneous write and read when full is impossible by construction. When empty, write then read on the next cycle; there is no bypass.
  - result and res_flags are held stable while out_valid && !out_ready.
- Sticky flags: sticky_flags |= res_flags on every buffer write. flag_clr clears them, but a same-cycle set wins for the bits being set, so no event is lost.
- res_count increments on every buffer write and wraps at 2^CNT_W.

Decomposition:
- Package fmul_pkg: FP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, and a flag index enum {FLG_UNF=0, FLG_OVF=1, FLG_INV=2}.
- Sub-module fmul_classify: combinational a/b/c → result and flags. The buffer stays inline in fmul_post_stage.

Test Plan:
- 2.0×3.0 (a=0x40000000, b=0x40400000, c=0x40C00000), out_ready=1 → result 0x40C00000, flags 0, out_valid exactly 2 cycles after accept, res_count=1.
- a=0x7F000000, b=0x7F000000, c=any → result 0x7F800000, overflow=1, sticky_flags=3'b010. flag_clr pulse → 0.
- a=0x00800000, b=0x00800000 → result 0x00000000 with underflow=1. a=0x80000000 × 0x3F800000 → result 0x80000000, flags 0.
- a=0x7F800000 × b=0x00000000 → result 0x7FC00000, invalid=1. a=0xFF800000 × 0x3F800000 → result 0xFF800000.
- Hold out_ready=0 and drive 4 back-to-back triples → in_ready drops after 2 accepts. Release → 2 results in order, then resume accepting; no loss or duplication.
- Assert rst while buffer holds 2 entries → next cycle out_valid=0, in_ready=1, res_count=0, sticky_flags=0.
